uart_debug_ctrl: RTL and testbench

Debug command controller between the UART transceiver and the CPU/memory debug ports. Parses host byte packets (ping, halt, go, word write, word read) and drives the instruction and data memory backdoor ports. Drives the CPU halt line and returns ACK or read data bytes to the transceiver for transmission.

---
 rtl/uart_debug_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_debug_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_ctrl.sv
// Debug command controller: parses host packets from the UART (ping, halt, go,
// word write, word read), drives the memory backdoor ports and returns ACK/data.
module uart_debug_ctrl #(
  parameter logic [31:0] DMEM_BASE    = 32'h0000_4000,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        imem_we,
  output logic        dmem_we,
  output logic        imem_re,
  output logic        dmem_re,
  output logic [31:0] debug_addr,
  output logic [31:0] debug_data,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] dmem_rdata,
  output logic        cpu_halt
);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WR, RD_REQ, RD_CAP, SEND, SEND_WAIT
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h41;

  state_t      state_q;
  logic        is_wr_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] tx_buf_q;
  logic [2:0]  tx_cnt_q;
  logic [31:0] to_cnt_q;
  logic        wait_first_q;
  logic        dsel_q;
  logic        cpu_halt_q;
  logic [7:0]  tx_byte_q;
  logic        imem_we_q, dmem_we_q, imem_re_q, dmem_re_q;

  logic [31:0] addr_d;
  logic [31:0] data_d;
  logic [31:0] rdata_sel;
  logic        timeout;

  assign addr_d    = {addr_q[23:0], rx_byte};
  assign data_d    = {data_q[23:0], rx_byte};
  assign rdata_sel = dsel_q ? dmem_rdata : imem_rdata;
  assign timeout   = (to_cnt_q == TIMEOUT_CLKS);

  assign debug_addr = {addr_q[31:2], 2'b00};
  assign debug_data = data_q;
  assign cpu_halt   = cpu_halt_q;
  assign tx_byte    = tx_byte_q;
  assign imem_we    = imem_we_q;
  assign dmem_we    = dmem_we_q;
  assign imem_re    = imem_re_q;
  assign dmem_re    = dmem_re_q;
  // Gated by the live tx_busy so a transceiver still busy after reset is honoured.
  assign tx_start   = (state_q == SEND) && !tx_busy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      is_wr_q      <= 1'b0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      tx_buf_q     <= '0;
      tx_cnt_q     <= '0;
      to_cnt_q     <= '0;
      wait_first_q <= 1'b0;
      dsel_q       <= 1'b0;
      cpu_halt_q   <= 1'b1;
      tx_byte_q    <= '0;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      imem_re_q    <= 1'b0;
      dmem_re_q    <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      imem_re_q <= 1'b0;
      dmem_re_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            case (rx_byte)
              CMD_W, CMD_R: begin
                is_wr_q    <= (rx_byte == CMD_W);
                byte_cnt_q <= '0;
                to_cnt_q   <= '0;
                state_q    <= ADDR;
              end
              CMD_P, CMD_H, CMD_G: begin
                if (rx_byte == CMD_H) cpu_halt_q <= 1'b1;
                if (rx_byte == CMD_G) cpu_halt_q <= 1'b0;
                tx_buf_q  <= {ACK, 24'h0};
                tx_cnt_q  <= 3'd1;
                tx_byte_q <= ACK;
                state_q   <= SEND;
              end
              default: ;
            endcase
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr_q     <= addr_d;
            to_cnt_q   <= '0;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= DATA;
              end else begin
                // Read strobe is registered on entry so it is high while in RD_REQ.
                dsel_q    <= (addr_d >= DMEM_BASE);
                dmem_re_q <= (addr_d >= DMEM_BASE);
                imem_re_q <= (addr_d <  DMEM_BASE);
                state_q   <= RD_REQ;
              end
            end
          end else if (timeout) begin
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            data_q     <= data_d;
            to_cnt_q   <= '0;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              dmem_we_q <= (addr_q >= DMEM_BASE);
              imem_we_q <= (addr_q <  DMEM_BASE);
              state_q   <= WR;
            end
          end else if (timeout) begin
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        WR: begin
          tx_buf_q  <= {ACK, 24'h0};
          tx_cnt_q  <= 3'd1;
          tx_byte_q <= ACK;
          state_q   <= SEND;
        end
        RD_REQ: state_q <= RD_CAP;
        RD_CAP: begin
          tx_buf_q  <= rdata_sel;
          tx_cnt_q  <= 3'd4;
          tx_byte_q <= rdata_sel[31:24];
          state_q   <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            wait_first_q <= 1'b1;
            state_q      <= SEND_WAIT;
          end
        end
        SEND_WAIT: begin
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (!tx_busy) begin
            tx_buf_q <= {tx_buf_q[23:0], 8'h00};
            tx_cnt_q <= tx_cnt_q - 3'd1;
            if (tx_cnt_q == 3'd1) begin
              state_q <= IDLE;
            end else begin
              tx_byte_q <= tx_buf_q[23:16];
              state_q   <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Directed bench for uart_debug_ctrl with a small transceiver model and
// strobe/transmit monitors.
module tb_uart_debug_ctrl;

  localparam int unsigned TO = 40;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        imem_we, dmem_we, imem_re, dmem_re;
  logic [31:0] debug_addr, debug_data;
  logic [31:0] imem_rdata = '0;
  logic [31:0] dmem_rdata = '0;
  logic        cpu_halt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx_log[$];
  int          starts_seen = 0;
  int          starts_done = 0;
  int          busy_cnt    = 0;
  int          iwe_cnt = 0, dwe_cnt = 0, ire_cnt = 0, dre_cnt = 0;
  logic [31:0] iw_addr = '0, iw_data = '0, dw_addr = '0, dw_data = '0;

  uart_debug_ctrl #(.DMEM_BASE(32'h0000_4000), .TIMEOUT_CLKS(TO)) dut (
    .CLK(CLK), .RST(RST), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .imem_we(imem_we), .dmem_we(dmem_we), .imem_re(imem_re), .dmem_re(dmem_re),
    .debug_addr(debug_addr), .debug_data(debug_data),
    .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata), .cpu_halt(cpu_halt)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (tx_start) begin tx_log.push_back(tx_byte); starts_seen++; end
    if (imem_we) begin iwe_cnt++; iw_addr = debug_addr; iw_data = debug_data; end
    if (dmem_we) begin dwe_cnt++; dw_addr = debug_addr; dw_data = debug_data; end
    if (imem_re) ire_cnt++;
    if (dmem_re) dre_cnt++;
  end

  // Transceiver: busy rises the cycle after tx_start and stays up for 6 cycles.
  always @(posedge CLK) begin
    #1;
    if (starts_done != starts_seen) begin
      starts_done = starts_seen;
      tx_busy     = 1'b1;
      busy_cnt    = 6;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  function automatic logic [7:0] logb(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction

  function automatic int strobes();
    return iwe_cnt + dwe_cnt + ire_cnt + dre_cnt;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1; rx_byte = b; rx_valid = 1'b1;
    @(posedge CLK); #1; rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    n_checks++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_halt: got %b want 1", cpu_halt); end
    n_checks++; if ({imem_we, dmem_we, imem_re, dmem_re} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {imem_we, dmem_we, imem_re, dmem_re}); end
    n_checks++; if (debug_addr !== 32'h0) begin n_fail++; $display("FAIL reset_debug_addr: got %h want 0", debug_addr); end
    n_checks++; if (debug_data !== 32'h0) begin n_fail++; $display("FAIL reset_debug_data: got %h want 0", debug_data); end
    @(posedge CLK); #1; RST = 1'b0;
    idle(2);
  endtask

  task automatic test_ping;
    int b, s;
    b = tx_log.size(); s = strobes();
    send_byte(8'h50);
    @(negedge CLK);
    n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL ping_latency: tx_start got %b want 1", tx_start); end
    n_checks++; if (tx_byte !== 8'h41) begin n_fail++; $display("FAIL ping_tx_byte: got %h want 41", tx_byte); end
    idle(30);
    n_checks++; if (tx_log.size() !== b + 1) begin n_fail++; $display("FAIL ping_count: got %0d bytes want 1", tx_log.size() - b); end
    n_checks++; if (logb(b) !== 8'h41) begin n_fail++; $display("FAIL ping_ack: got %h want 41", logb(b)); end
    n_checks++; if (strobes() !== s) begin n_fail++; $display("FAIL ping_strobes: got %0d want 0", strobes() - s); end
    n_checks++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL ping_halt: got %b want 1", cpu_halt); end
  endtask

  task automatic test_write_read;
    int b, iw, dw, ir, dr;
    logic [7:0] wpkt [9];
    logic [7:0] rpkt [5];
    logic [31:0] got;
    wpkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rpkt = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
    b = tx_log.size(); iw = iwe_cnt; dw = dwe_cnt;
    foreach (wpkt[i]) send_byte(wpkt[i]);
    @(negedge CLK);
    n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL wr_strobe_latency: imem_we got %b want 1", imem_we); end
    n_checks++; if (debug_addr !== 32'h10) begin n_fail++; $display("FAIL wr_addr: got %h want 00000010", debug_addr); end
    n_checks++; if (debug_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data: got %h want deadbeef", debug_data); end
    @(negedge CLK);
    n_checks++; if ({imem_we, tx_start} !== 2'b01) begin n_fail++; $display("FAIL wr_ack_latency: {we,tx_start} got %b want 01", {imem_we, tx_start}); end
    idle(30);
    n_checks++; if (iwe_cnt - iw !== 1 || dwe_cnt - dw !== 0) begin n_fail++; $display("FAIL wr_counts: imem %0d dmem %0d want 1 0", iwe_cnt - iw, dwe_cnt - dw); end
    n_checks++; if (tx_log.size() !== b + 1 || logb(b) !== 8'h41) begin n_fail++; $display("FAIL wr_ack: got %0d bytes first %h want 1 byte 41", tx_log.size() - b, logb(b)); end

    imem_rdata = 32'hDEADBEEF; dmem_rdata = 32'h12345678;
    b = tx_log.size(); ir = ire_cnt; dr = dre_cnt;
    foreach (rpkt[i]) send_byte(rpkt[i]);
    @(negedge CLK);
    n_checks++; if (imem_re !== 1'b1) begin n_fail++; $display("FAIL rd_strobe_latency: imem_re got %b want 1", imem_re); end
    idle(80);
    got = {logb(b), logb(b + 1), logb(b + 2), logb(b + 3)};
    n_checks++; if (tx_log.size() !== b + 4) begin n_fail++; $display("FAIL rd_count: got %0d bytes want 4", tx_log.size() - b); end
    n_checks++; if (got !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_bytes: got %h want deadbeef", got); end
    n_checks++; if (ire_cnt - ir !== 1 || dre_cnt - dr !== 0) begin n_fail++; $display("FAIL rd_counts: imem %0d dmem %0d want 1 0", ire_cnt - ir, dre_cnt - dr); end
  endtask

  task automatic test_routing;
    int iw, dw, b;
    logic [7:0] p1 [9];
    logic [7:0] p2 [9];
    logic [7:0] p3 [5];
    logic [31:0] got;
    p1 = '{8'h57, 8'h00, 8'h00, 8'h40, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    p2 = '{8'h57, 8'h00, 8'h00, 8'h3F, 8'hFC, 8'h55, 8'h66, 8'h77, 8'h88};
    p3 = '{8'h52, 8'h00, 8'h00, 8'h40, 8'h00};
    iw = iwe_cnt; dw = dwe_cnt;
    foreach (p1[i]) send_byte(p1[i]);
    idle(30);
    n_checks++; if (dwe_cnt - dw !== 1 || iwe_cnt - iw !== 0) begin n_fail++; $display("FAIL route_dmem: dmem %0d imem %0d want 1 0", dwe_cnt - dw, iwe_cnt - iw); end
    n_checks++; if (dw_addr !== 32'h4000 || dw_data !== 32'h11223344) begin n_fail++; $display("FAIL route_dmem_mask: addr %h data %h want 00004000 11223344", dw_addr, dw_data); end
    iw = iwe_cnt; dw = dwe_cnt;
    foreach (p2[i]) send_byte(p2[i]);
    idle(30);
    n_checks++; if (iwe_cnt - iw !== 1 || dwe_cnt - dw !== 0) begin n_fail++; $display("FAIL route_imem_edge: imem %0d dmem %0d want 1 0", iwe_cnt - iw, dwe_cnt - dw); end
    n_checks++; if (iw_addr !== 32'h3FFC || iw_data !== 32'h55667788) begin n_fail++; $display("FAIL route_imem_addr: addr %h data %h want 00003ffc 55667788", iw_addr, iw_data); end
    imem_rdata = 32'h0BADF00D; dmem_rdata = 32'hCAFEF00D;
    b = tx_log.size();
    foreach (p3[i]) send_byte(p3[i]);
    idle(80);
    got = {logb(b), logb(b + 1), logb(b + 2), logb(b + 3)};
    n_checks++; if (got !== 32'hCAFEF00D) begin n_fail++; $display("FAIL route_dmem_read: got %h want cafef00d", got); end
  endtask

  task automatic test_halt_go;
    int b;
    b = tx_log.size();
    send_byte(8'h47);
    @(negedge CLK);
    n_checks++; if (cpu_halt !== 1'b0) begin n_fail++; $display("FAIL go: cpu_halt got %b want 0", cpu_halt); end
    idle(20);
    send_byte(8'h47);
    @(negedge CLK);
    n_checks++; if (cpu_halt !== 1'b0) begin n_fail++; $display("FAIL go_again: cpu_halt got %b want 0", cpu_halt); end
    idle(20);
    send_byte(8'h48);
    @(negedge CLK);
    n_checks++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL halt: cpu_halt got %b want 1", cpu_halt); end
    idle(20);
    n_checks++; if (tx_log.size() !== b + 3 || {logb(b), logb(b + 1), logb(b + 2)} !== 24'h414141) begin n_fail++; $display("FAIL halt_go_acks: got %0d bytes %h%h%h want 3 x 41", tx_log.size() - b, logb(b), logb(b + 1), logb(b + 2)); end
  endtask

  task automatic test_back_to_back;
    int b;
    b = tx_log.size();
    send_byte(8'h50);
    send_byte(8'h47);
    idle(30);
    n_checks++; if (tx_log.size() !== b + 1) begin n_fail++; $display("FAIL drop_busy_count: got %0d bytes want 1", tx_log.size() - b); end
    n_checks++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL drop_busy_halt: got %b want 1", cpu_halt); end
  endtask

  task automatic test_robustness;
    int b, s;
    b = tx_log.size(); s = strobes();
    send_byte(8'h00);
    idle(20);
    n_checks++; if (tx_log.size() !== b || strobes() !== s) begin n_fail++; $display("FAIL unknown_cmd: got %0d bytes %0d strobes want 0 0", tx_log.size() - b, strobes() - s); end
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(TO + 10);
    send_byte(8'h50);
    idle(30);
    n_checks++; if (tx_log.size() !== b + 1 || logb(b) !== 8'h41) begin n_fail++; $display("FAIL timeout_then_ping: got %0d bytes first %h want 1 byte 41", tx_log.size() - b, logb(b)); end
    n_checks++; if (strobes() !== s) begin n_fail++; $display("FAIL timeout_strobes: got %0d want 0", strobes() - s); end
  endtask

  task automatic test_reset_mid_read;
    int b, t;
    logic [7:0] p [5];
    p = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    send_byte(8'h47);
    idle(20);
    imem_rdata = 32'hA1B2C3D4;
    b = tx_log.size();
    foreach (p[i]) send_byte(p[i]);
    t = 0;
    while (tx_log.size() < b + 2 && t < 200) begin @(negedge CLK); t++; end
    n_checks++; if (logb(b + 1) !== 8'hB2) begin n_fail++; $display("FAIL rst_mid_second_byte: got %h want b2", logb(b + 1)); end
    @(posedge CLK); #1; RST = 1'b1; #1;
    n_checks++; if (tx_start !== 1'b0 || {imem_we, dmem_we, imem_re, dmem_re} !== 4'b0) begin n_fail++; $display("FAIL rst_mid_outputs: tx_start %b strobes %b want 0 0000", tx_start, {imem_we, dmem_we, imem_re, dmem_re}); end
    n_checks++; if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL rst_mid_halt: got %b want 1", cpu_halt); end
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    idle(20);
    b = tx_log.size();
    send_byte(8'h50);
    idle(30);
    n_checks++; if (tx_log.size() !== b + 1 || logb(b) !== 8'h41) begin n_fail++; $display("FAIL rst_then_ping: got %0d bytes first %h want 1 byte 41", tx_log.size() - b, logb(b)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ping();
    test_write_read();
    test_routing();
    test_halt_go();
    test_back_to_back();
    test_robustness();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
